key_click_decoder: RTL and testbench

- Sits directly downstream of the key debounce stage.
- Consumes its one-cycle "press confirmed" pulse and groups successive presses separated by less than a gap window into one click event.
- Emits one event pulse carrying the click count (single/double/triple/...), so application logic can distinguish multi-click gestures from a single button.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_click_decoder_if.sv | 28 ++
 rtl/key_gap_timer.sv | 32 +++
 rtl/key_click_decoder.sv | 101 ++++++++++
 tb/tb_key_click_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key input chain: the click-decoder state
// encoding and the counter widths reused by the debounce stage.
package key_pkg;

    localparam int CLICK_W = 3;
    localparam int GAP_W   = 24;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Increment a click count, holding it once it reaches the limit.
    function automatic logic [CLICK_W-1:0] sat_inc(
        input logic [CLICK_W-1:0] value,
        input logic [CLICK_W-1:0] limit
    );
        return (value < limit) ? value + 1'b1 : value;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Press input and click-event outputs of the click decoder.
// master drives presses and observes events; slave is the decoder.
interface key_click_decoder_if;
    import key_pkg::*;

    logic               key_flag;
    logic               evt_valid;
    logic [CLICK_W-1:0] evt_clicks;
    logic               evt_sat;
    logic               busy;

    modport master (
        output key_flag,
        input  evt_valid,
        input  evt_clicks,
        input  evt_sat,
        input  busy
    );

    modport slave (
        input  key_flag,
        output evt_valid,
        output evt_clicks,
        output evt_sat,
        output busy
    );

endinterface

// File: rtl/key_gap_timer.sv
// Inactivity timer for an open click group. Counts cycles while run is
// high, stops at GAP_CNT (never wraps) and flags expire at that value.
module key_gap_timer
    import key_pkg::*;
#(
    parameter logic [GAP_W-1:0] GAP_CNT = 24'd12_499_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    logic [GAP_W-1:0] count_q;

    // Count up while running; clear has priority and returns the count to 0.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run && (count_q < GAP_CNT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = (count_q == GAP_CNT);

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses separated by less than GAP_CNT idle cycles
// into a single click event, reporting the (saturating) press count.
module key_click_decoder
    import key_pkg::*;
#(
    parameter logic [GAP_W-1:0]   GAP_CNT    = 24'd12_499_999,
    parameter logic [CLICK_W-1:0] MAX_CLICKS = 3'd4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    key_click_decoder_if.slave  bus
);

    state_t             state_q, state_d;
    logic [CLICK_W-1:0] clicks_q, clicks_d;
    logic               sat_q, sat_d;
    logic               evt_valid_q, evt_valid_d;
    logic [CLICK_W-1:0] evt_clicks_q, evt_clicks_d;
    logic               evt_sat_q, evt_sat_d;

    logic timer_clear;
    logic timer_run;
    logic timer_expire;

    key_gap_timer #(
        .GAP_CNT (GAP_CNT)
    ) u_gap_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expire  (timer_expire)
    );

    // Register FSM state, the running group and the event outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            clicks_q     <= '0;
            sat_q        <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_clicks_q <= '0;
            evt_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clicks_q     <= clicks_d;
            sat_q        <= sat_d;
            evt_valid_q  <= evt_valid_d;
            evt_clicks_q <= evt_clicks_d;
            evt_sat_q    <= evt_sat_d;
        end
    end

    // Next-state logic: open a group on a press, extend it on each further
    // press (a press beats a simultaneous timeout), close it on timeout.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        clicks_d     = clicks_q;
        sat_d        = sat_q;
        evt_valid_d  = 1'b0;
        evt_clicks_d = evt_clicks_q;
        evt_sat_d    = evt_sat_q;
        timer_clear  = 1'b1;
        timer_run    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.key_flag) begin
                    state_d  = COLLECT;
                    clicks_d = CLICK_W'(1);
                    sat_d    = 1'b0;
                end
            end
            COLLECT: begin
                if (bus.key_flag) begin
                    clicks_d = sat_inc(clicks_q, MAX_CLICKS);
                    sat_d    = sat_q | (clicks_q >= MAX_CLICKS);
                end else if (timer_expire) begin
                    evt_valid_d  = 1'b1;
                    evt_clicks_d = clicks_q;
                    evt_sat_d    = sat_q;
                    state_d      = IDLE;
                end else begin
                    timer_clear = 1'b0;
                    timer_run   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.evt_valid  = evt_valid_q;
    assign bus.evt_clicks = evt_clicks_q;
    assign bus.evt_sat    = evt_sat_q;
    assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_key_click_decoder.sv
// Scoreboard bench for key_click_decoder: directed gesture scenarios plus
// random press streams, checked against a press-counting reference model.
module tb_key_click_decoder;

    localparam int GAP = 10;
    localparam int MAX = 4;

    typedef struct {
        int cyc;
        int clicks;
        int sat;
    } evt_t;

    logic sys_clk;
    logic sys_rst;

    key_click_decoder_if bus ();

    key_click_decoder #(
        .GAP_CNT    (24'(GAP)),
        .MAX_CLICKS (3'(MAX))
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    evt_t exp_q[$];

    // Reference model state: a group is a list of press times; it closes
    // once GAP+1 edges pass with no press after the last one.
    int cyc      = 0;
    bit m_open   = 1'b0;
    int m_cnt    = 0;
    int m_last   = 0;
    int held_clk = 0;
    int held_sat = 0;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model, evaluated on each rising edge with pre-edge inputs.
    always @(posedge sys_clk) begin
        evt_t e;
        cyc++;
        if (sys_rst) begin
            m_open = 1'b0;
            m_cnt  = 0;
        end else if (bus.key_flag) begin
            if (!m_open) begin
                m_open = 1'b1;
                m_cnt  = 0;
            end
            m_cnt++;
            m_last = cyc;
        end else if (m_open && (cyc - m_last == GAP + 1)) begin
            e.cyc    = cyc;
            e.clicks = (m_cnt > MAX) ? MAX : m_cnt;
            e.sat    = (m_cnt > MAX) ? 1 : 0;
            exp_q.push_back(e);
            m_open = 1'b0;
        end
    end

    // Monitor: shortly after each edge, compare busy, any event and the held outputs.
    always @(posedge sys_clk) begin
        evt_t e;
        #1;
        check("busy", 32'(bus.busy), 32'(m_open));
        if (bus.evt_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", 32'(bus.evt_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
                check("evt_clicks", 32'(bus.evt_clicks), 32'(e.clicks));
                check("evt_sat", 32'(bus.evt_sat), 32'(e.sat));
                held_clk = e.clicks;
                held_sat = e.sat;
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_evt", 32'(bus.evt_valid), 32'd1);
        end
        if (sys_rst) begin
            held_clk = 0;
            held_sat = 0;
        end
        check("held_clicks", 32'(bus.evt_clicks), 32'(held_clk));
        check("held_sat", 32'(bus.evt_sat), 32'(held_sat));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk) bus.key_flag = 1'b0;
    endtask

    task automatic press();
        @(negedge sys_clk) bus.key_flag = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'd0);
        check({tag, "_evt_clicks"}, 32'(bus.evt_clicks), 32'd0);
        check({tag, "_evt_sat"}, 32'(bus.evt_sat), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int density;
        sys_rst      = 1'b1;
        bus.key_flag = 1'b0;
        idle(3);
        #1;
        check_all_zero("reset");
        @(negedge sys_clk) sys_rst = 1'b0;
        idle(4);

        // Single click.
        press(); idle(20);
        // Double click, second press 7 cycles later.
        press(); idle(6); press(); idle(20);
        // Six presses 3 cycles apart: saturates at MAX with sat set.
        repeat (6) begin press(); idle(2); end
        idle(20);
        // Second press lands exactly when the timer reaches GAP.
        press(); idle(GAP); press(); idle(20);
        // Second press coincides with the first event pulse.
        press(); idle(GAP + 1); press(); idle(20);
        // Back-to-back presses held high for 3 and then 6 cycles.
        repeat (3) press();
        idle(20);
        repeat (6) press();
        idle(20);

        // Reset in the middle of an open group discards it.
        press(); idle(2); press(); idle(1);
        check("busy_before_reset", 32'(bus.busy), 32'd1);
        @(negedge sys_clk) begin
            bus.key_flag = 1'b0;
            sys_rst      = 1'b1;
        end
        #1;
        check_all_zero("mid_reset");
        idle(2);
        @(negedge sys_clk) sys_rst = 1'b0;
        idle(3);
        press(); idle(20);

        // Random press streams at increasing densities.
        for (int d = 0; d < 4; d++) begin
            density = (d == 0) ? 5 : (d == 1) ? 15 : (d == 2) ? 40 : 80;
            for (int i = 0; i < 150; i++) begin
                @(negedge sys_clk) bus.key_flag = ($urandom_range(0, 99) < density);
            end
            idle(GAP + 5);
        end
        idle(GAP + 5);

        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
